// File: rtl/calculation_unit_scheduler_if.sv
// Issue/result bundle between a request source and calculation_unit_scheduler.
// Selects travel as raw 3-bit codes; the scheduler decodes them to calculation::calculation_select.
interface calculation_unit_scheduler_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 op_valid;
  logic                 op_ready;
  logic [2:0]           op_select;
  logic [TAG_WIDTH-1:0] op_tag;
  logic                 iter_start;
  logic                 iter_is_sqrt;
  logic                 iter_step;
  logic                 busy;
  logic [2:0]           calculation_select;
  logic                 result_valid;
  logic [TAG_WIDTH-1:0] result_tag;

  modport master (
    output op_valid, op_select, op_tag,
    input  op_ready, iter_start, iter_is_sqrt, iter_step, busy,
    input  calculation_select, result_valid, result_tag
  );

  modport slave (
    input  op_valid, op_select, op_tag,
    output op_ready, iter_start, iter_is_sqrt, iter_step, busy,
    output calculation_select, result_valid, result_tag
  );
endinterface

// File: rtl/calculation_unit_scheduler.sv
// In-order issue controller: ADD/SUB/MUL stream through a fixed-latency pipe, DIV/SQRT run
// one at a time on the shared iterative engine; results leave in acceptance order.
package calculation;
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    SQRT = 3'd4
  } calculation_select;
endpackage

module calculation_unit_scheduler #(
  parameter int PIPE_LATENCY    = 3,
  parameter int DIV_ITERATIONS  = 25,
  parameter int SQRT_ITERATIONS = 25,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  calculation_unit_scheduler_if.slave   bus
);
  import calculation::*;

  localparam int MAX_ITER = (DIV_ITERATIONS > SQRT_ITERATIONS) ? DIV_ITERATIONS : SQRT_ITERATIONS;
  localparam int CNT_W    = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  typedef enum logic [1:0] {IDLE, ITERATE, FINISH} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 iter_sqrt_q;
  logic [TAG_WIDTH-1:0] iter_tag_q;

  logic [PIPE_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  calculation_select       pipe_sel_q [PIPE_LATENCY];
  logic [TAG_WIDTH-1:0]    pipe_tag_q [PIPE_LATENCY];

  calculation_select    op_sel;
  logic                 op_is_iter;
  logic                 pipe_busy;
  logic                 ready;
  logic                 accept;
  logic                 start;
  logic                 step;
  logic                 is_sqrt;
  logic                 out_pipe;
  logic                 out_fin;
  calculation_select    res_sel;
  logic [TAG_WIDTH-1:0] res_tag;

  // Encodings beyond SQRT fall back to ADD.
  always_comb begin
    op_sel = ADD;
    if (bus.op_select <= 3'(SQRT)) op_sel = calculation_select'(bus.op_select);
  end

  assign op_is_iter = (op_sel == DIV) || (op_sel == SQRT);
  assign pipe_busy  = |pipe_vld_q;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    accept  = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
    is_sqrt = 1'b0;
    case (state_q)
      IDLE: begin
        // Iterative ops wait for the pipe to drain so results stay ordered.
        ready  = !reset && !flush && !(op_is_iter && pipe_busy);
        accept = bus.op_valid && ready;
        if (accept && op_is_iter) begin
          start   = 1'b1;
          is_sqrt = (op_sel == SQRT);
          state_d = ITERATE;
          cnt_d   = (op_sel == SQRT) ? CNT_W'(SQRT_ITERATIONS - 1) : CNT_W'(DIV_ITERATIONS - 1);
        end
      end
      ITERATE: begin
        step    = 1'b1;
        is_sqrt = iter_sqrt_q;
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    pipe_vld_d = '0;
    if (!flush) begin
      pipe_vld_d[0] = accept && !op_is_iter;
      for (int i = 1; i < PIPE_LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pipe_vld_q  <= '0;
      iter_sqrt_q <= 1'b0;
      iter_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      if (start) begin
        iter_sqrt_q <= (op_sel == SQRT);
        iter_tag_q  <= bus.op_tag;
      end
    end
  end

  // NOTE: the pipe payload is left unreset; it is only observed through its valid bit,
  // which is reset.
  always_ff @(posedge clk) begin
    pipe_sel_q[0] <= op_sel;
    pipe_tag_q[0] <= bus.op_tag;
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      pipe_sel_q[i] <= pipe_sel_q[i-1];
      pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
  end

  // The pipe is always empty while the engine is in FINISH, so the two sources never overlap.
  assign out_pipe = pipe_vld_q[PIPE_LATENCY-1];
  assign out_fin  = (state_q == FINISH);

  always_comb begin
    res_sel = ADD;
    res_tag = '0;
    if (out_fin) begin
      res_sel = iter_sqrt_q ? SQRT : DIV;
      res_tag = iter_tag_q;
    end else if (out_pipe) begin
      res_sel = pipe_sel_q[PIPE_LATENCY-1];
      res_tag = pipe_tag_q[PIPE_LATENCY-1];
    end
  end

  assign bus.op_ready           = ready;
  assign bus.iter_start         = start;
  assign bus.iter_step          = step;
  assign bus.iter_is_sqrt       = is_sqrt;
  assign bus.busy               = pipe_busy || (state_q != IDLE);
  assign bus.result_valid       = out_fin || out_pipe;
  assign bus.calculation_select = res_sel;
  assign bus.result_tag         = res_tag;
endmodule

// File: tb/tb_calculation_unit_scheduler.sv
// Bench for calculation_unit_scheduler: directed scenarios then random traffic, checked against
// a per-cycle event schedule built from acceptance times and fixed latencies.
module tb_calculation_unit_scheduler;
  import calculation::*;

  localparam int PIPE_LATENCY = 3;
  localparam int DIV_IT       = 25;
  localparam int SQRT_IT      = 25;
  localparam int TW           = 4;
  localparam int N            = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  calculation_unit_scheduler_if #(.TAG_WIDTH(TW)) bus ();

  calculation_unit_scheduler #(
    .PIPE_LATENCY   (PIPE_LATENCY),
    .DIV_ITERATIONS (DIV_IT),
    .SQRT_ITERATIONS(SQRT_IT),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference: results scheduled by cycle, plus the window of the active engine job.
  bit          m_rv   [N];
  logic [2:0]  m_rsel [N];
  logic [TW-1:0] m_rtag [N];
  int  last_pipe, it_acc, it_len, eng_end;
  bit  it_sqrt, m_acc;
  int  n_step, n_block;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
      $error("check %s", name);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) m_rv[i] = 1'b0;
    last_pipe = -1000;
    it_acc    = -1000;
    it_len    = 0;
    eng_end   = -1000;
    it_sqrt   = 1'b0;
    m_acc     = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 ns later, then advance the model.
  task automatic step(input bit v, input logic [2:0] s, input logic [TW-1:0] t, input bit f);
    logic [2:0] esel;
    bit pbusy, idle, iter_op, exp_ready, in_iter, start;
    int lat;
    @(negedge clk);
    bus.op_valid  = v;
    bus.op_select = s;
    bus.op_tag    = t;
    flush         = f;
    #1;
    esel      = (s > 3'(SQRT)) ? 3'(ADD) : s;
    iter_op   = (esel == 3'(DIV)) || (esel == 3'(SQRT));
    pbusy     = (cyc > last_pipe) && (cyc <= last_pipe + PIPE_LATENCY);
    idle      = (cyc > eng_end);
    exp_ready = !f && idle && !(iter_op && pbusy);
    m_acc     = v && exp_ready;
    start     = m_acc && iter_op;
    in_iter   = (cyc > it_acc) && (cyc <= it_acc + it_len);

    check("op_ready",     32'(bus.op_ready),           32'(exp_ready));
    check("result_valid", 32'(bus.result_valid),       32'(m_rv[cyc]));
    check("select",       32'(bus.calculation_select), m_rv[cyc] ? 32'(m_rsel[cyc]) : 32'(ADD));
    check("result_tag",   32'(bus.result_tag),         m_rv[cyc] ? 32'(m_rtag[cyc]) : 32'd0);
    check("iter_start",   32'(bus.iter_start),         32'(start));
    check("iter_step",    32'(bus.iter_step),          32'(in_iter));
    check("busy",         32'(bus.busy),               32'(pbusy || !idle));
    if (start || in_iter)
      check("iter_is_sqrt", 32'(bus.iter_is_sqrt), start ? 32'(esel == 3'(SQRT)) : 32'(it_sqrt));

    n_step  += int'(bus.iter_step);
    n_block += int'(!bus.op_ready);

    if (f) begin
      for (int i = cyc + 1; i < cyc + 40; i++) m_rv[i] = 1'b0;
      last_pipe = -1000;
      it_acc    = -1000;
      eng_end   = cyc;
    end else if (m_acc) begin
      if (iter_op) begin
        lat     = ((esel == 3'(SQRT)) ? SQRT_IT : DIV_IT) + 1;
        it_acc  = cyc;
        it_len  = lat - 1;
        it_sqrt = (esel == 3'(SQRT));
        eng_end = cyc + lat;
      end else begin
        lat       = PIPE_LATENCY;
        last_pipe = cyc;
      end
      m_rv[cyc+lat]   = 1'b1;
      m_rsel[cyc+lat] = esel;
      m_rtag[cyc+lat] = t;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)), TW'($urandom), 1'b0);
  endtask

  // Hold a request until the reference model says it is taken; bounded wait.
  task automatic send(input logic [2:0] s, input logic [TW-1:0] t);
    int n = 0;
    do begin
      step(1'b1, s, t, 1'b0);
      n++;
    end while (!m_acc && n < 64);
    check("accepted_within_budget", 32'(m_acc), 32'd1);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before any clock edge.
  task automatic async_reset(input int hold);
    #2;
    reset         = 1'b1;
    bus.op_valid  = 1'b1;
    bus.op_select = 3'(DIV);
    #1;
    check("rst_op_ready",     32'(bus.op_ready),           32'd0);
    check("rst_result_valid", 32'(bus.result_valid),       32'd0);
    check("rst_result_tag",   32'(bus.result_tag),         32'd0);
    check("rst_select",       32'(bus.calculation_select), 32'(ADD));
    check("rst_iter_start",   32'(bus.iter_start),         32'd0);
    check("rst_iter_step",    32'(bus.iter_step),          32'd0);
    check("rst_iter_is_sqrt", 32'(bus.iter_is_sqrt),       32'd0);
    check("rst_busy",         32'(bus.busy),               32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset        = 1'b0;
    bus.op_valid = 1'b0;
    clear_model();
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_select = 3'(ADD);
    bus.op_tag    = '0;
    clear_model();

    // Reset values, then op_ready the cycle after release.
    async_reset(2);
    idle_cycles(2);

    // Three pipelined ops back to back.
    send(3'(ADD), 4'd1);
    send(3'(SUB), 4'd2);
    send(3'(MUL), 4'd3);
    idle_cycles(5);

    // DIV held off behind a MUL until the pipe drains.
    send(3'(MUL), 4'd5);
    n_block = 0;
    send(3'(DIV), 4'd6);
    check("div_holdoff_cycles", 32'(n_block), 32'(PIPE_LATENCY));
    idle_cycles(DIV_IT + 3);

    // SQRT with an ADD queued behind it.
    send(3'(SQRT), 4'd9);
    n_step  = 0;
    n_block = 0;
    send(3'(ADD), 4'd7);
    check("sqrt_step_count", 32'(n_step),  32'(SQRT_IT));
    check("sqrt_block_count", 32'(n_block), 32'(SQRT_IT + 1));
    idle_cycles(4);

    // Unknown encoding behaves as ADD.
    send(3'd7, 4'hE);
    idle_cycles(4);

    // Flush on iteration 10 of a DIV, with a same-cycle request that must be refused.
    send(3'(DIV), 4'd10);
    idle_cycles(9);
    step(1'b1, 3'(SUB), 4'd13, 1'b1);
    send(3'(SUB), 4'd11);
    idle_cycles(4);

    // Flush with two pipelined ops in flight.
    send(3'(ADD), 4'd1);
    send(3'(MUL), 4'd2);
    step(1'b0, 3'(ADD), 4'd0, 1'b1);
    send(3'(ADD), 4'd4);
    idle_cycles(5);

    // Async reset in the middle of ITERATE; nothing stale may surface afterwards.
    send(3'(DIV), 4'd12);
    idle_cycles(5);
    async_reset(2);
    idle_cycles(DIV_IT + 5);

    // Random traffic including unknown selects and occasional flushes.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, 3'($urandom % 8), TW'($urandom), ($urandom % 40) == 0);
    idle_cycles(DIV_IT + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
